// File: rtl/gba_obj_pkg.sv
// Shared types and constants for the OBJ (sprite) line evaluation path.
package gba_obj_pkg;

  localparam int unsigned OBJ_ENTRIES = 128;

  // {bit9, affine} pattern that marks an entry as switched off.
  localparam logic [1:0] OBJ_DISABLE_BITS = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRd01,
    StRd2,
    StOut,
    StDone
  } obj_state_t;

  typedef enum logic [1:0] {
    ShapeSquare,
    ShapeWide,
    ShapeTall,
    ShapeBad
  } obj_shape_t;

  typedef struct packed {
    obj_shape_t  shape;
    logic [3:0]  misc;
    logic        bit9;
    logic        affine;
    logic [7:0]  y;
  } obj_attr0_t;

  typedef struct packed {
    logic [1:0]  size;
    logic [13:0] misc;
  } obj_attr1_t;

  typedef struct packed {
    logic [15:0] attr2;
    obj_attr1_t  attr1;
    obj_attr0_t  attr0;
  } obj_attr_t;

endpackage

// File: rtl/obj_height_lut.sv
// Sprite height decode: shape/size/double-size -> height in lines, flags shape 3.
module obj_height_lut
  import gba_obj_pkg::*;
(
  input  obj_shape_t  shape,
  input  logic [1:0]  size,
  input  logic        dbl,
  output logic [7:0]  height,
  output logic        invalid
);

  logic [7:0] base;

  // Base height table, doubled for affine double-size sprites.
  always_comb begin
    base    = 8'd8;
    invalid = 1'b0;
    unique case (shape)
      ShapeSquare: begin
        unique case (size)
          2'd0: base = 8'd8;
          2'd1: base = 8'd16;
          2'd2: base = 8'd32;
          2'd3: base = 8'd64;
        endcase
      end
      ShapeWide: begin
        unique case (size)
          2'd0: base = 8'd8;
          2'd1: base = 8'd8;
          2'd2: base = 8'd16;
          2'd3: base = 8'd32;
        endcase
      end
      ShapeTall: begin
        unique case (size)
          2'd0: base = 8'd16;
          2'd1: base = 8'd32;
          2'd2: base = 8'd32;
          2'd3: base = 8'd64;
        endcase
      end
      ShapeBad: invalid = 1'b1;
    endcase
    height = dbl ? {base[6:0], 1'b0} : base;
  end

endmodule

// File: rtl/oam_line_scanner.sv
// Walks every OAM entry for one scanline and streams out the visible sprites.
module oam_line_scanner
  import gba_obj_pkg::*;
#(
  parameter int unsigned ENTRIES   = OBJ_ENTRIES,
  parameter logic [13:0] BASE_WORD = 14'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  line,
  output logic        busy,
  output logic [13:0] oam_addr,
  input  logic [31:0] oam_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_index,
  output logic [15:0] out_attr0,
  output logic [15:0] out_attr1,
  output logic [15:0] out_attr2,
  output logic [6:0]  out_row,
  output logic        done,
  output logic [7:0]  hit_count
);

  localparam int unsigned   IdxW    = $clog2(ENTRIES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ENTRIES - 1);

  obj_state_t      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [13:0]     addr_q, addr_d;
  logic [7:0]      line_q;
  obj_attr_t       attr_q;
  logic [6:0]      row_q;
  logic [7:0]      hits_q;

  obj_attr0_t      rd_a0;
  obj_attr1_t      rd_a1;
  logic [7:0]      height;
  logic            shape_bad;
  logic            disabled;
  logic            dbl;
  logic [7:0]      rd_row;
  logic [7:0]      cap_row;
  logic            hit;
  logic            last;

  // Decode the {attr1, attr0} word straight off the read port.
  assign rd_a0    = obj_attr0_t'(oam_rdata[15:0]);
  assign rd_a1    = obj_attr1_t'(oam_rdata[31:16]);
  assign disabled = ({rd_a0.bit9, rd_a0.affine} == OBJ_DISABLE_BITS);
  assign dbl      = rd_a0.bit9 & rd_a0.affine;
  // 8-bit wrap lets sprites with Y near 255 reach the top lines.
  assign rd_row   = line_q - rd_a0.y;
  assign hit      = !disabled && !shape_bad && (rd_row < height);
  assign last     = (idx_q == LastIdx);
  assign cap_row  = line_q - attr_q.attr0.y;

  obj_height_lut u_height_lut (
    .shape   (rd_a0.shape),
    .size    (rd_a1.size),
    .dbl     (dbl),
    .height  (height),
    .invalid (shape_bad)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and entry index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRd01;
          idx_d   = '0;
        end
      end
      StRd01: begin
        if (hit) begin
          state_d = StRd2;
        end else if (last) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StRd2: state_d = StOut;
      StOut: begin
        if (out_ready) begin
          if (last) begin
            state_d = StDone;
          end else begin
            state_d = StRd01;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Address is registered, so it is set up from the state being entered.
  always_comb begin
    addr_d = addr_q;
    if (state_d == StRd01) begin
      addr_d = BASE_WORD + 14'({idx_d, 1'b0});
    end else if (state_d == StRd2) begin
      addr_d = BASE_WORD + 14'({idx_d, 1'b1});
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != StIdle);
    out_valid = (state_q == StOut);
    done      = (state_q == StDone);
  end

  // Datapath: index, address, captured line, record fields and hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      addr_q <= BASE_WORD;
      line_q <= '0;
      attr_q <= '0;
      row_q  <= '0;
      hits_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
      if (state_q == StIdle && start) begin
        line_q <= line;
        hits_q <= '0;
      end
      if (state_q == StRd01) begin
        attr_q.attr0 <= rd_a0;
        attr_q.attr1 <= rd_a1;
      end
      if (state_q == StRd2) begin
        attr_q.attr2 <= oam_rdata[15:0];
        row_q        <= cap_row[6:0];
      end
      if (state_q == StOut && out_ready) begin
        hits_q <= hits_q + 8'd1;
      end
    end
  end

  assign oam_addr  = addr_q;
  assign out_index = 7'(idx_q);
  assign out_attr0 = attr_q.attr0;
  assign out_attr1 = attr_q.attr1;
  assign out_attr2 = attr_q.attr2;
  assign out_row   = row_q;
  assign hit_count = hits_q;

endmodule

// File: doc/oam_line_scanner.md
# oam_line_scanner

Per-scanline sprite evaluator directly downstream of the OAM word memory. On a start pulse it walks all OAM entries through one read port, decodes Y, shape, size and the affine/double-size bits, and emits each entry visible on the requested line. Each visible entry goes out as a record on a valid/ready stream to the OBJ line renderer. It finishes with a done pulse and a hit count.

## Interface
- `ENTRIES`, 128: OAM entries scanned, index width `$clog2(ENTRIES)`.
- `BASE_WORD`, 14'h0000: word address of entry 0 in OAM.
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a scan. Accepted only when `busy`=0; ignored otherwise.
- `line` in 8: scanline, captured when `start` is accepted.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `oam_addr` out 14: registered word address to the OAM read port.
- `oam_rdata` in 32: OAM read data. Combinational, so it is valid in the same cycle as `oam_addr`.
- `out_valid` out 1: a sprite record is presented.
- `out_ready` in 1: downstream accepts the record.
- `out_index` out 7: OAM entry index.
- `out_attr0`, `out_attr1`, `out_attr2` out 16 each: raw attributes.
- `out_row` out 7: row within the sprite, `(line - Y) mod 256`.
- `done` out 1: one-cycle pulse at the end of the scan.
- `hit_count` out 8: number of records emitted in the last scan. Holds until the next `start`.

## Operation
- Entry i layout:
  - word `BASE_WORD+2i` = {attr1, attr0}
  - word `BASE_WORD+2i+1` low half = attr2
- Fields:
  - Y = attr0[7:0]
  - affine = attr0[8]
  - bit9 = attr0[9]
  - shape = attr0[15:14]
  - size = attr1[15:14]
- Disabled when affine=0 and bit9=1. Shape 3 is prohibited. Both are skipped as misses.
- Base height by shape/size 0..3:
  - square: 8, 16, 32, 64
  - wide: 8, 8, 16, 32
  - tall: 16, 32, 32, 64
- Effective height = base×2 when affine=1 and bit9=1 (max 128).
- row = (line − Y) mod 256, 8-bit wrap. Hit iff row < effective height. Y near 255 therefore wraps onto lines 0.. (Y=200, h=64 hits lines 200–255 and 0–7).
- States: IDLE, RD01, RD2, OUT, DONE.
  - IDLE: on `start`, capture `line`, clear `idx` and `hit_count`, go to RD01.
  - RD01: `oam_addr`=BASE+2·idx. Evaluate `oam_rdata` and capture attr0/attr1.
    - Hit: go to RD2.
    - Miss with idx=ENTRIES−1: go to DONE.
    - Miss otherwise: idx+1, stay in RD01.
  - RD2: `oam_addr`=BASE+2·idx+1. Capture attr2 and row, go to OUT.
  - OUT: `out_valid`=1 and record stable until `out_ready`. On handshake: `hit_count`+1, then DONE if idx is last, else idx+1 and RD01.
  - DONE: `done`=1 for one cycle, `busy` drops, go to IDLE.
- No record is ever dropped. A stalled `out_ready` stalls the scan.

## Timing
- Reset values:
  - state IDLE
  - `busy` 0, `out_valid` 0, `done` 0
  - `hit_count` 0
  - `oam_addr` BASE_WORD
  - all record outputs 0
- `oam_addr` changes only on clock edges.
- Miss costs 1 cycle/entry. A hit costs 3 cycles/entry plus stall cycles.
- With `start` in cycle 0, an all-miss scan has RD01 in cycles 1–128 and `done` in cycle 129.
- Hit on entry 0 with `out_ready`=1: RD01 in cycle 1, RD2 in cycle 2, `out_valid` in cycle 3.
- `start` coinciding with `done` is ignored, since `busy` is still 1.
- `rst` mid-scan or mid-OUT returns all outputs to reset values on the next edge. The pending record is discarded.

## Structure
- Package `gba_obj_pkg`:
  - `obj_state_t` enum
  - `obj_shape_t`
  - packed `obj_attr_t` (attr0/1/2 field views)
  - constants `OBJ_ENTRIES`, `OBJ_DISABLE_BITS`
- Sub-module `obj_height_lut`: combinational shape/size/double → height (8 bits) plus `invalid` flag for shape 3. It is the only natural split; the rest is one FSM module.

## Test plan
- Empty OAM (all entries attr0=0x0200, disabled), line=10 → no `out_valid`, `done` exactly 129 cycles after `start`, `hit_count`=0.
- Entry 5: attr0=0x0010 (Y=16, square), attr1=0x4000 (16px), attr2=0x0123, line=20, `out_ready`=1 → one record: index 5, row 4, attr2 0x0123, `hit_count`=1.
- Wrap: entry 0 Y=250 square 32px, line=3 → hit, row=9. Same entry, line=30 → miss.
- Affine double: attr0=0x0350 (Y=0x50, affine, double), square 8px, line=0x5F → hit, row 15. Line=0x60 → miss.
- Backpressure: three hits, `out_ready` low 5 cycles on the second → records held stable, order 0,1,2 kept, `hit_count`=3.
- `rst` asserted while `out_valid`=1 → next cycle `out_valid`=0, `busy`=0, `hit_count`=0. A subsequent `start` rescans from entry 0.
